// File: rtl/wb_ecall_sequencer.sv
// GPR write-port owner between MEM/WB and the regfile.
// Sequences ECALL: drain in-flight writebacks, handshake, write x10.
module wb_ecall_sequencer #(
    parameter int INFL_W      = 4,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_issue,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    input  logic        ecall_valid,
    output logic        ecall_ready,
    output logic        stall,
    output logic        sys_req,
    input  logic        sys_ack,
    input  logic [63:0] sys_ret,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic        wbex_valid,
    output logic [4:0]  wbex_rd,
    output logic [63:0] wbex_rdval,
    output logic        ecalldone,
    output logic        ecall_err,
    output logic        proto_err
);

    localparam int TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [TW-1:0]     TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0]     TMO_ONE  = TW'(1);
    localparam logic [INFL_W-1:0] INFL_MAX = '1;
    localparam logic [INFL_W-1:0] INFL_ONE = INFL_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_CALL,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [INFL_W-1:0]  infl_q, infl_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               proto_q, proto_d;
    logic               we_q, we_d;
    logic [4:0]         waddr_q, waddr_d;
    logic [63:0]        wdata_q, wdata_d;

    assign ecall_ready = (state_q == S_IDLE);
    assign stall       = (state_q != S_IDLE);
    assign sys_req     = (state_q == S_CALL);
    assign ecalldone   = (state_q == S_DONE);
    assign ecall_err   = (state_q == S_DONE) && err_q;
    assign proto_err   = proto_q;
    assign rf_we       = we_q;
    assign rf_waddr    = waddr_q;
    assign rf_wdata    = wdata_q;
    assign wbex_valid  = we_q;
    assign wbex_rd     = waddr_q;
    assign wbex_rdval  = wdata_q;

    always_comb begin
        state_d = state_q;
        infl_d  = infl_q;
        tmo_d   = '0;
        err_d   = err_q;
        proto_d = proto_q;
        we_d    = wb_valid && (wb_rd != 5'd0);
        waddr_d = wb_rd;
        wdata_d = wb_data;

        unique case (state_q)
            S_IDLE: begin
                err_d = 1'b0;
                if (ecall_valid && ecall_ready) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (infl_q == '0 && !wb_valid) state_d = S_CALL;
            end
            S_CALL: begin
                if (wb_valid) proto_d = 1'b1;
                // The handler result owns the write port on the ack edge.
                if (sys_ack) begin
                    state_d = S_DONE;
                    we_d    = 1'b1;
                    waddr_d = 5'd10;
                    wdata_d = sys_ret;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_ONE;
                end
            end
            S_DONE: begin
                if (wb_valid) proto_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        unique case ({ex_issue, wb_valid})
            2'b10: begin
                if (infl_q == INFL_MAX) proto_d = 1'b1;
                else                    infl_d  = infl_q + INFL_ONE;
            end
            2'b01: begin
                if (infl_q == '0) proto_d = 1'b1;
                else              infl_d  = infl_q - INFL_ONE;
            end
            default: ;
        endcase

        if (ex_issue && stall) proto_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            infl_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            proto_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            infl_q  <= infl_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            proto_q <= proto_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_ecall_sequencer.sv
// Scoreboard bench for wb_ecall_sequencer.
// Writes and ECALL completions are queued at issue and checked by a monitor.
module tb_wb_ecall_sequencer;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_issue = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [63:0] wb_data = '0;
    logic        ecall_valid = 1'b0;
    logic        ecall_ready;
    logic        stall;
    logic        sys_req;
    logic        sys_ack = 1'b0;
    logic [63:0] sys_ret = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        wbex_valid;
    logic [4:0]  wbex_rd;
    logic [63:0] wbex_rdval;
    logic        ecalldone;
    logic        ecall_err;
    logic        proto_err;

    wb_ecall_sequencer #(.INFL_W(4), .ACK_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ex_issue(ex_issue), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_data(wb_data),
        .ecall_valid(ecall_valid), .ecall_ready(ecall_ready),
        .stall(stall), .sys_req(sys_req),
        .sys_ack(sys_ack), .sys_ret(sys_ret),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .wbex_valid(wbex_valid), .wbex_rd(wbex_rd),
        .wbex_rdval(wbex_rdval),
        .ecalldone(ecalldone), .ecall_err(ecall_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [68:0] wq[$];
    bit          dq[$];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write / completion must match the queue head.
    always @(negedge clk) begin
        logic [68:0] e;
        if (reset) begin
            if (rf_we) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexp_write: got x%0d=%0h want none",
                             rf_waddr, rf_wdata);
                end else begin
                    e = wq.pop_front();
                    check("wr_addr", 64'(rf_waddr), 64'(e[68:64]));
                    check("wr_data", rf_wdata, e[63:0]);
                    check("byp_valid", 64'(wbex_valid), 64'd1);
                    check("byp_rd", 64'(wbex_rd), 64'(e[68:64]));
                    check("byp_val", wbex_rdval, e[63:0]);
                end
            end else if (wbex_valid) begin
                check("byp_idle", 64'(wbex_valid), 64'd0);
            end
            if (ecalldone) begin
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexp_done: got ecalldone want none");
                end else begin
                    check("done_err", 64'(ecall_err), 64'(dq.pop_front()));
                end
            end else if (ecall_err) begin
                check("err_no_done", 64'(ecall_err), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        ex_issue = 1'b1;
        tick();
        ex_issue = 1'b0;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [63:0] d);
        wb_valid = 1'b1;
        wb_rd    = rd;
        wb_data  = d;
        if (rd != 5'd0) wq.push_back({rd, d});
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic accept();
        ecall_valid = 1'b1;
        tick();
        ecall_valid = 1'b0;
    endtask

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_ready", 64'(ecall_ready), 64'd1);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_req", 64'(sys_req), 64'd0);
        check("rst_we", 64'(rf_we), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        check("rst_done", 64'(ecalldone), 64'd0);
        check("rst_err", 64'(ecall_err), 64'd0);
        check("rst_proto", 64'(proto_err), 64'd0);
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Passthrough, including the x0 suppression
        issue();
        issue();
        wb(5'd5, 64'hDEAD_BEEF);
        check("pt_we", 64'(rf_we), 64'd1);
        check("pt_addr", 64'(rf_waddr), 64'd5);
        check("pt_data", rf_wdata, 64'hDEAD_BEEF);
        wb(5'd0, 64'h1234);
        check("pt_x0_we", 64'(rf_we), 64'd0);
        check("pt_proto", 64'(proto_err), 64'd0);

        // ECALL with empty pipeline: ack at cycle 6
        check("ec_ready0", 64'(ecall_ready), 64'd1);
        accept();
        check("ec_stall1", 64'(stall), 64'd1);
        check("ec_ready1", 64'(ecall_ready), 64'd0);
        check("ec_req1", 64'(sys_req), 64'd0);
        tick();
        check("ec_req2", 64'(sys_req), 64'd1);
        repeat (4) tick();
        check("ec_req6", 64'(sys_req), 64'd1);
        sys_ack = 1'b1;
        sys_ret = 64'h2A;
        wq.push_back({5'd10, 64'h2A});
        dq.push_back(1'b0);
        tick();
        sys_ack = 1'b0;
        check("ec_done7", 64'(ecalldone), 64'd1);
        check("ec_req7", 64'(sys_req), 64'd0);
        check("ec_we7", 64'(rf_we), 64'd1);
        tick();
        check("ec_ready8", 64'(ecall_ready), 64'd1);
        check("ec_stall8", 64'(stall), 64'd0);

        // ECALL drain: wb at cycles 2, 4, 5; CALL at 7
        repeat (3) issue();
        accept();
        tick();
        wb(5'd7, 64'h7777);
        tick();
        wb(5'd8, 64'h8888);
        wb(5'd9, 64'h9999);
        check("dr_req6", 64'(sys_req), 64'd0);
        tick();
        check("dr_req7", 64'(sys_req), 64'd1);
        sys_ack = 1'b1;
        sys_ret = 64'hCAFE;
        wq.push_back({5'd10, 64'hCAFE});
        dq.push_back(1'b0);
        tick();
        sys_ack = 1'b0;
        check("dr_done", 64'(ecalldone), 64'd1);
        tick();

        // Timeout: done+err TMO cycles after CALL entry, no write
        accept();
        tick();
        check("to_req", 64'(sys_req), 64'd1);
        dq.push_back(1'b1);
        for (int i = 1; i < TMO; i++) begin
            tick();
            check("to_early", 64'(ecalldone), 64'd0);
        end
        tick();
        check("to_done", 64'(ecalldone), 64'd1);
        check("to_err", 64'(ecall_err), 64'd1);
        check("to_we", 64'(rf_we), 64'd0);
        tick();
        check("to_stall", 64'(stall), 64'd0);

        // Randomized legal traffic
        for (int it = 0; it < 40; it++) begin
            int k;
            int b;
            int d;
            bit to;
            k = int'($urandom_range(0, 3));
            repeat (k) issue();
            if ($urandom_range(0, 1) == 0) begin
                for (int j = 0; j < k; j++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    wb(5'($urandom_range(0, 31)), {$urandom(), $urandom()});
                end
            end else begin
                b = cyc;
                accept();
                for (int j = 0; j < k; j++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    b = cyc;
                    wb(5'($urandom_range(0, 31)), {$urandom(), $urandom()});
                end
                for (int n = 0; n < 30 && !sys_req; n++) tick();
                check("rnd_call_cyc", 64'(cyc), 64'(b + 2));
                to = ($urandom_range(0, 5) == 0);
                if (to) begin
                    dq.push_back(1'b1);
                end else begin
                    d = int'($urandom_range(0, TMO - 1));
                    repeat (d) tick();
                    sys_ack = 1'b1;
                    sys_ret = {$urandom(), $urandom()};
                    wq.push_back({5'd10, sys_ret});
                    dq.push_back(1'b0);
                    tick();
                    sys_ack = 1'b0;
                end
                for (int n = 0; n < 30 && !ecall_ready; n++) tick();
                check("rnd_ready", 64'(ecall_ready), 64'd1);
            end
        end
        tick();
        check("rnd_proto", 64'(proto_err), 64'd0);

        // Protocol errors
        wb(5'd3, 64'h55);
        check("pe_set", 64'(proto_err), 64'd1);
        tick();
        check("pe_held", 64'(proto_err), 64'd1);
        accept();
        tick();
        sys_ack  = 1'b1;
        sys_ret  = 64'h77;
        wb_valid = 1'b1;
        wb_rd    = 5'd4;
        wb_data  = 64'h99;
        wq.push_back({5'd10, 64'h77});
        dq.push_back(1'b0);
        tick();
        sys_ack  = 1'b0;
        wb_valid = 1'b0;
        check("pe_ack_addr", 64'(rf_waddr), 64'd10);
        check("pe_ack_data", rf_wdata, 64'h77);
        tick();
        check("pe_still", 64'(proto_err), 64'd1);

        // Async reset while in CALL
        accept();
        tick();
        check("ar_req", 64'(sys_req), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("ar_ready", 64'(ecall_ready), 64'd1);
        check("ar_stall", 64'(stall), 64'd0);
        check("ar_req0", 64'(sys_req), 64'd0);
        check("ar_proto", 64'(proto_err), 64'd0);
        check("ar_we", 64'(rf_we), 64'd0);
        tick();
        reset   = 1'b1;
        sys_ack = 1'b1;
        sys_ret = 64'hBAD;
        tick();
        sys_ack = 1'b0;
        repeat (3) tick();
        check("ar_idle", 64'(stall), 64'd0);

        check("wq_empty", 64'(wq.size()), 64'd0);
        check("dq_empty", 64'(dq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_ecall_sequencer.md
# wb_ecall_sequencer

Owns the single GPR write port between the MEM/WB stage and the register file, and sequences ECALL retirement. Normal writebacks pass through a one-cycle registered write stage that also drives the EX bypass. An ECALL stalls the front of the pipeline, drains all in-flight writebacks, and runs a req/ack handshake with the system-call handler. It then writes the handler's return value into x10 and pulses `ecalldone`.

## Interface
- `INFL_W`, default 4: width of the in-flight writeback counter; saturates at 2^INFL_W-1.
- `ACK_TIMEOUT`, default 1024: cycles to wait in CALL for `sys_ack` before aborting.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `ex_issue` in 1: an instruction that will write back left EX this cycle; increments the in-flight count.
- `wb_valid` in 1: writeback request from MEM/WB this cycle; decrements the in-flight count.
- `wb_rd` in 5: destination register.
- `wb_data` in 64: write data, already muxed between ALU result and load data.
- `ecall_valid` in 1: ECALL present at MEM/WB.
- `ecall_ready` out 1: high only in IDLE; the ECALL is accepted when `ecall_valid & ecall_ready`.
- `stall` out 1: holds fetch/decode/issue; high in DRAIN, CALL and DONE.
- `sys_req` out 1: system-call request, high throughout CALL.
- `sys_ack` in 1: handler done; sampled only in CALL.
- `sys_ret` in 64: handler return value, valid with `sys_ack`.
- `rf_we` out 1: regfile write enable (registered).
- `rf_waddr` out 5: regfile write address (registered).
- `rf_wdata` out 64: regfile write data (registered).
- `wbex_valid` out 1: bypass valid; equals `rf_we`.
- `wbex_rd` out 5: bypass register; equals `rf_waddr`.
- `wbex_rdval` out 64: bypass value; equals `rf_wdata`.
- `ecalldone` out 1: one-cycle pulse at ECALL completion.
- `ecall_err` out 1: one-cycle pulse, coincident with `ecalldone`, when the ECALL timed out.
- `proto_err` out 1: sticky; cleared only by reset.

## Operation
- States: IDLE, DRAIN, CALL, DONE.
- IDLE:
  - On ECALL accept, go to DRAIN.
  - `wb_valid` writes normally.
- DRAIN:
  - Go to CALL when `infl==0 && !wb_valid`.
  - Writebacks still retire while draining.
- CALL:
  - `sys_req` is high and the timeout counter increments.
  - On `sys_ack`, load the write register with x10/`sys_ret` and go to DONE.
  - If the counter reaches ACK_TIMEOUT-1 with no ack, go to DONE with no write and flag the error for `ecall_err`.
- DONE:
  - `ecalldone`=1 (and `ecall_err` if flagged).
  - Return to IDLE next cycle.
- Write register:
  - Each cycle it loads `wb_valid`/`wb_rd`/`wb_data`, except on the CALL ack edge, where ECALL data wins.
  - `rf_we` is forced to 0 when the selected address is x0.
- In-flight counter:
  - `ex_issue` and `wb_valid` in the same cycle leave it unchanged.
  - An increment at max saturates.
  - A decrement at 0 holds 0.
  - Both saturation and decrement-at-0 set `proto_err`.
- `wb_valid` in CALL or DONE is a protocol violation:
  - Sets `proto_err`.
  - The write is still performed, except on the ack edge, where it is dropped.
- `ex_issue` while `stall`=1 sets `proto_err`; the count is still updated.

## Timing
- Reset values:
  - All outputs 0, except `ecall_ready`=1.
  - State IDLE, in-flight count 0, timeout counter 0.
- Writeback latency: `wb_valid` at cycle n gives `rf_we`/`wbex_*` at cycle n+1, for one cycle.
- ECALL with empty pipeline: accept at cycle 0, DRAIN at 1, CALL (`sys_req`) at 2.
  - With `sys_ack` at cycle k≥2, the x10 write and `ecalldone` occur at k+1, and `ecall_ready` returns at k+2.
- `sys_ack` in the first CALL cycle is legal.
- `sys_req` drops in the cycle after ack or timeout.
- Timeout: `ecalldone` and `ecall_err` are asserted ACK_TIMEOUT cycles after CALL entry; there is no write.
- `stall` is asserted the cycle after accept and falls when the state returns to IDLE.
- Reset low mid-operation: the block immediately returns to reset values and any pending ECALL is abandoned without a write.

## Test plan
- Writeback passthrough: `wb_valid`, rd=5, data=0xDEAD_BEEF at cycle 3 -> `rf_we`=1, addr 5, data 0xDEADBEEF at cycle 4 only. The same with rd=0 -> `rf_we`=0.
- ECALL with empty pipeline: ECALL at cycle 0, `sys_ack` at cycle 6 with `sys_ret`=0x2A -> `sys_req` high on cycles 2–6; `rf_we` to x10 with 0x2A and `ecalldone` at cycle 7; `ecall_ready`=1 at cycle 8.
- ECALL drain: three `ex_issue` pulses, ECALL accepted, then `wb_valid` at cycles 2, 4, 5 -> `sys_req` first at cycle 7; all three writes appear on `rf_*`.
- Timeout with ACK_TIMEOUT=8 and no ack -> `ecalldone`=1 and `ecall_err`=1 eight cycles after CALL entry; no `rf_we`; `stall` drops the next cycle.
- Protocol errors:
  - `wb_valid` with the in-flight count at 0 -> `proto_err`=1, held.
  - `wb_valid` coincident with `sys_ack` -> only the x10 write is performed.
- Async reset: `reset` low for 1 cycle while in CALL -> all outputs 0 (`ecall_ready`=1) without waiting for a clock edge; no x10 write afterwards.
